// File: rtl/output_credit_unit.sv
// -----------------------------------------------------------------------------
// output_credit_unit
//
// Per-output-port stage that sits after the input-unit controllers and the
// crossbar. There is one instance for each output direction.
//
// The block does three jobs:
//   * It tracks the free slots in the downstream router's input FIFO, which is
//     the credit count. credit_avail is exported so that switch allocation
//     does not grant this port when the downstream buffer is full.
//   * It registers the flit leaving the crossbar onto the output link.
//   * It checks that every credit decrement (an SA grant) is followed, exactly
//     one cycle later, by one valid flit from switch traversal.
//
// Ports
//   clk            in   system clock
//   rst            in   asynchronous, active-high reset
//   credit_decre   in   OR of all input units' decrement bits for this port
//                       (SA-grant cycle)
//   st_valid       in   crossbar output valid for this port
//   st_data        in   crossbar output flit
//   credit_in      in   credit-return pulse from the downstream router
//   credit_avail   out  high while credit_count is non-zero
//   credit_count   out  current credit counter
//   out_valid      out  registered flit valid to the downstream link
//   out_data       out  registered flit to the downstream link
//   err_overflow   out  sticky: a credit came back while the counter was full
//   err_underflow  out  sticky: a decrement arrived with zero credits
//   err_protocol   out  sticky: st_valid disagreed with the previous cycle's
//                       credit_decre
// -----------------------------------------------------------------------------
module output_credit_unit #(
  parameter int DATA_WIDTH = 36,
  parameter int BUF_DEPTH  = 4,
  parameter int CNT_WIDTH  = $clog2(BUF_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  credit_decre,
  input  logic                  st_valid,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic                  credit_in,
  output logic                  credit_avail,
  output logic [CNT_WIDTH-1:0]  credit_count,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  err_overflow,
  output logic                  err_underflow,
  output logic                  err_protocol
);

  // Full-scale credit value. The counter reloads to this value on reset.
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(BUF_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0]  credit_count_q, credit_count_d;
  logic                  out_valid_q,    out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,     out_data_d;
  logic                  decre_d1_q,     decre_d1_d;
  logic                  err_overflow_q,  err_overflow_d;
  logic                  err_underflow_q, err_underflow_d;
  logic                  err_protocol_q,  err_protocol_d;

  // ---------------------------------------------------------------------------
  // Credit counter
  // ---------------------------------------------------------------------------
  // When a return and a decrement arrive in the same cycle they cancel out.
  // This holds at either boundary as well, so only the one-sided events can
  // move the counter or raise an error.
  logic credit_up;
  logic credit_dn;
  logic overflow_set;
  logic underflow_set;

  assign credit_up = credit_in    & ~credit_decre;
  assign credit_dn = credit_decre & ~credit_in;

  always_comb begin
    credit_count_d = credit_count_q;
    overflow_set   = 1'b0;
    underflow_set  = 1'b0;
    if (credit_up) begin
      if (credit_count_q == CNT_FULL) begin
        // Extra credit with nowhere to go: saturate and flag it.
        overflow_set = 1'b1;
      end else begin
        credit_count_d = credit_count_q + CNT_ONE;
      end
    end else if (credit_dn) begin
      if (credit_count_q == CNT_ZERO) begin
        // A grant was issued with no credit: saturate and flag it.
        underflow_set = 1'b1;
      end else begin
        credit_count_d = credit_count_q - CNT_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Link register
  // ---------------------------------------------------------------------------
  // out_data keeps its last flit while the link is idle. This avoids toggling
  // the wide link bus for no reason.
  always_comb begin
    out_valid_d = st_valid;
    out_data_d  = st_valid ? st_data : out_data_q;
  end

  // ---------------------------------------------------------------------------
  // Grant / traversal pairing check
  // ---------------------------------------------------------------------------
  // A grant in cycle T must produce a crossbar flit in T+1, and no flit may
  // appear without a grant. Comparing st_valid against the grant delayed by
  // one cycle catches both a missing flit and a spurious flit.
  logic protocol_set;

  assign decre_d1_d   = credit_decre;
  assign protocol_set = st_valid ^ decre_d1_q;

  // All error flags are sticky until reset.
  always_comb begin
    err_overflow_d  = err_overflow_q  | overflow_set;
    err_underflow_d = err_underflow_q | underflow_set;
    err_protocol_d  = err_protocol_q  | protocol_set;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // Reset drops any in-flight flit and reloads the full credit count. The
  // downstream FIFO is cleared by the same reset, so the two stay consistent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_count_q  <= CNT_FULL;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      decre_d1_q      <= 1'b0;
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
      err_protocol_q  <= 1'b0;
    end else begin
      credit_count_q  <= credit_count_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      decre_d1_q      <= decre_d1_d;
      err_overflow_q  <= err_overflow_d;
      err_underflow_q <= err_underflow_d;
      err_protocol_q  <= err_protocol_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // credit_avail is decoded from the counter register only. Keeping
  // credit_decre and credit_in out of this path avoids a combinational loop
  // through switch allocation.
  assign credit_avail  = (credit_count_q != CNT_ZERO);
  assign credit_count  = credit_count_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign err_overflow  = err_overflow_q;
  assign err_underflow = err_underflow_q;
  assign err_protocol  = err_protocol_q;

endmodule
